// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch/decode instruction buffer.
package fetch_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      DRAIN
   } fdb_state_t;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] instr;
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] pc_plus_4;
   } fdb_entry_t;

endpackage

// File: rtl/fdb_fifo.sv
// Circular entry store for the fetch/decode buffer; flush empties it in one cycle.
module fdb_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         din_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [WIDTH-1:0]         head_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
   end

   // Empty buffer presents zeros so stale storage never leaks to decode.
   assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/fetch_decode_buffer.sv
// Decouples instruction-memory fetch from decode with a small in-order buffer.
// Optional perf counters (stall_cycles, flush_count) under FETCH_DECODE_BUFFER_PERF_EN.
module fetch_decode_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   parameter int unsigned DEPTH = 2
) (
   input  logic            clock,
   input  logic            async_reset,
   input  logic [XLEN-1:0] PC_F,
   input  logic [XLEN-1:0] PC_plus_4_F,
   input  logic            flush_E,
   input  logic            stall_D,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   output logic            enable_fetch,
   output logic [XLEN-1:0] instruction_D,
   output logic [XLEN-1:0] PC_D,
   output logic [XLEN-1:0] PC_plus_4_D,
   output logic            valid_D
`ifdef FETCH_DECODE_BUFFER_PERF_EN
   ,
   output logic [31:0]     stall_cycles,
   output logic [31:0]     flush_count
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fdb_state_t        state_q, state_d;
   logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
   logic [XLEN-1:0]   pend_pc4_q, pend_pc4_d;
   logic [CW-1:0]     count, occ_after_pop;
   logic [3*XLEN-1:0] push_data, head;
   logic              push, pop, space_ok, issue;

   assign valid_D       = (count != '0);
   assign pop           = valid_D & ~stall_D;
   assign occ_after_pop = count - CW'(pop);
   assign space_ok      = (occ_after_pop < CW'(DEPTH));
   // Reset gates issue directly so outputs hold reset values while PC_F is live.
   assign issue         = async_reset & (state_q == IDLE) & ~flush_E & space_ok;
   assign pend_pc_d     = issue ? PC_F : pend_pc_q;
   assign pend_pc4_d    = issue ? PC_plus_4_F : pend_pc4_q;

   always_ff @(posedge clock or negedge async_reset) begin
      if (!async_reset) begin
         state_q    <= IDLE;
         pend_pc_q  <= '0;
         pend_pc4_q <= '0;
      end else begin
         state_q    <= state_d;
         pend_pc_q  <= pend_pc_d;
         pend_pc4_q <= pend_pc4_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (issue && !imem_ack) state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (imem_ack)     state_d = IDLE;
            else if (flush_E) state_d = DRAIN;
         end
         DRAIN:    if (imem_ack) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_req     = 1'b0;
      imem_addr    = '0;
      enable_fetch = 1'b0;
      push         = 1'b0;
      push_data    = {imem_rdata, PC_F, PC_plus_4_F};
      if (async_reset) begin
         enable_fetch = flush_E | issue;
         unique case (state_q)
            IDLE: begin
               if (issue) begin
                  imem_req  = 1'b1;
                  imem_addr = PC_F;
                  push      = imem_ack;
               end
            end
            WAIT_ACK: begin
               imem_req  = 1'b1;
               imem_addr = pend_pc_q;
               push      = imem_ack & ~flush_E;
               push_data = {imem_rdata, pend_pc_q, pend_pc4_q};
            end
            DRAIN: begin
               imem_req  = 1'b1;
               imem_addr = pend_pc_q;
            end
            default: ;
         endcase
      end
   end

   fdb_fifo #(
      .WIDTH (3*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (async_reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush_E),
      .din_i   (push_data),
      .count_o (count),
      .head_o  (head)
   );

   assign {instruction_D, PC_D, PC_plus_4_D} = head;

`ifdef FETCH_DECODE_BUFFER_PERF_EN
   logic [31:0] stall_cycles_q, flush_count_q;

   always_ff @(posedge clock or negedge async_reset) begin
      if (!async_reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (valid_D && stall_D && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 32'd1;
         if (flush_E && flush_count_q != '1)            flush_count_q  <= flush_count_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule
